// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
//   loader_state_t : loader FSM states
//   HDR_BYTES      : header length in bytes (16-bit little-endian instruction count)
//   BYTES_PER_INST : payload bytes per instruction word
//   MAX_COUNT      : capacity for the default 11-bit PC; max_count() derives it for any width
package prog_loader_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StHdrLo,   // alias of StIdle, never entered
        StHdrHi,
        StInstLo,
        StInstHi,
        StWrite,
        StHold,
        StRun,
        StFin
    } loader_state_t;

    localparam int unsigned HDR_BYTES        = 2;
    localparam int unsigned BYTES_PER_INST   = 2;
    localparam int unsigned DEFAULT_PC_WIDTH = 11;
    localparam int unsigned MAX_COUNT        = 2 ** DEFAULT_PC_WIDTH;

    function automatic int unsigned max_count(input int unsigned pc_width);
        return 32'd1 << pc_width;
    endfunction

endpackage

// File: rtl/loader_byte_pair.sv
// Assembles a low/high byte pair into a 9-bit instruction word.
//   clk_i, reset_i : clock, synchronous active-high reset
//   byte_i         : stream byte
//   lo_en_i        : latch byte_i as the low byte
//   hi_en_i        : byte_i is the high byte of the current pair
//   lo_byte_o      : last latched low byte
//   word_o         : {byte_i[0], lo_byte}; valid while hi_en_i is high
//   pair_done_o    : pair completes this cycle
module loader_byte_pair (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] byte_i,
    input  logic       lo_en_i,
    input  logic       hi_en_i,
    output logic [7:0] lo_byte_o,
    output logic [8:0] word_o,
    output logic       pair_done_o
);

    logic [7:0] lo_q, lo_d;

    always_comb begin
        lo_d = lo_q;
        if (lo_en_i) begin
            lo_d = byte_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lo_q <= 8'h00;
        end else begin
            lo_q <= lo_d;
        end
    end

    // Only bit 0 of the high byte carries data; bits 7:1 are ignored.
    assign word_o      = {byte_i[0], lo_q};
    assign pair_done_o = hi_en_i;
    assign lo_byte_o   = lo_q;

endmodule

// File: rtl/prog_loader.sv
// Host-side program loader: receives a byte stream (2-byte instruction count followed by
// 2 bytes per instruction), writes 9-bit words sequentially into instruction memory, holds
// the core in start until START_HOLD cycles after the last write, then waits for cpu_done.
//   clk, reset            : clock, synchronous active-high reset
//   byte_in/byte_valid    : stream input; byte_ready decoded from state (transfer = valid & ready)
//   mem_we/addr/data      : instruction memory write port, registered
//   cpu_start             : high holds the core at PC 0
//   cpu_done              : core finished
//   busy                  : high outside IDLE
//   load_done             : one-cycle pulse after cpu_done
//   load_err              : sticky header error, cleared by the next accepted header byte
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 11,
    parameter int unsigned INST_WIDTH = 9,
    parameter int unsigned START_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic [INST_WIDTH-1:0] mem_data,
    output logic                  cpu_start,
    input  logic                  cpu_done,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int unsigned CntW     = PC_WIDTH + 1;
    localparam int unsigned MaxCount = max_count(PC_WIDTH);

    loader_state_t state_q, state_d;
    logic                  mem_we_q, mem_we_d;
    logic [PC_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [INST_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  cpu_start_q, cpu_start_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [CntW-1:0]       written_q, written_d;
    logic [3:0]            hold_q, hold_d;

    logic                     rx_state;
    logic                     lo_en;
    logic                     hi_en;
    logic [7:0]               lo_byte;
    logic [8:0]               pair_word;
    logic                     pair_done;
    logic [HDR_BYTES*8-1:0]   hdr_count;
    logic                     hdr_bad;

    // Enables depend on registered state only, keeping the next-state logic loop-free.
    assign rx_state   = (state_q == StIdle)   || (state_q == StHdrLo) || (state_q == StHdrHi) ||
                        (state_q == StInstLo) || (state_q == StInstHi);
    assign byte_ready = rx_state && !reset;
    assign lo_en      = byte_valid && byte_ready &&
                        (state_q == StIdle || state_q == StHdrLo || state_q == StInstLo);
    assign hi_en      = byte_valid && byte_ready && (state_q == StInstHi);

    // The header low byte shares the pair's low-byte register.
    loader_byte_pair u_byte_pair (
        .clk_i      (clk),
        .reset_i    (reset),
        .byte_i     (byte_in),
        .lo_en_i    (lo_en),
        .hi_en_i    (hi_en),
        .lo_byte_o  (lo_byte),
        .word_o     (pair_word),
        .pair_done_o(pair_done)
    );

    assign hdr_count = {byte_in, lo_byte};
    assign hdr_bad   = ({16'd0, hdr_count} > MaxCount);

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        cpu_start_d = cpu_start_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        count_d     = count_q;
        written_d   = written_q;
        hold_d      = hold_q;

        unique case (state_q)
            StIdle, StHdrLo: begin
                if (lo_en) begin
                    load_err_d = 1'b0;
                    state_d    = StHdrHi;
                end
            end
            StHdrHi: begin
                if (byte_valid) begin
                    if (hdr_bad) begin
                        load_err_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        load_err_d = 1'b0;
                        count_d    = CntW'(hdr_count);
                        written_d  = '0;
                        mem_addr_d = '0;
                        if (hdr_count == '0) begin
                            hold_d  = '0;
                            state_d = StHold;
                        end else begin
                            state_d = StInstLo;
                        end
                    end
                end
            end
            StInstLo: begin
                if (lo_en) begin
                    state_d = StInstHi;
                end
            end
            StInstHi: begin
                if (pair_done) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = INST_WIDTH'(pair_word);
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                // Address advances after the strobe cycle; wraps only when count == capacity.
                mem_addr_d = mem_addr_q + PC_WIDTH'(1);
                written_d  = written_q + CntW'(1);
                if (written_q + CntW'(1) == count_q) begin
                    hold_d  = '0;
                    state_d = StHold;
                end else begin
                    state_d = StInstLo;
                end
            end
            StHold: begin
                if (hold_q == 4'(START_HOLD - 1)) begin
                    cpu_start_d = 1'b0;
                    state_d     = StRun;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            StRun: begin
                if (cpu_done) begin
                    cpu_start_d = 1'b1;
                    load_done_d = 1'b1;
                    state_d     = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cpu_start_q <= 1'b1;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            count_q     <= '0;
            written_q   <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cpu_start_q <= cpu_start_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            count_q     <= count_d;
            written_q   <= written_d;
            hold_q      <= hold_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign cpu_start = cpu_start_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: header decode, word writes, start hold, run/done handshake,
// header error, stalls, mid-load reset and a full-capacity load.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [8:0]  mem_data;
    logic        cpu_start;
    logic        cpu_done = 1'b0;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;

    // Write log captured at negedge.
    logic [10:0] wa[$];
    logic [8:0]  wd[$];
    logic        wr_rdy[$];
    int          wc[$];

    prog_loader #(
        .PC_WIDTH  (11),
        .INST_WIDTH(9),
        .START_HOLD(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_start (cpu_start),
        .cpu_done  (cpu_done),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wr_rdy.push_back(byte_ready);
            wc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wr_rdy.delete();
        wc.delete();
    endtask

    // Entered and left at posedge+1. Holds the byte until it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            byte_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(1, 0) == 0) break;
                @(posedge clk);
                #1;
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (byte_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                vec++;
                errs++;
                $display("FAIL send_byte_timeout: byte %h not accepted, required acceptance", b);
                byte_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Waits for release, pulses cpu_done after `delay` cycles, checks the completion pulse.
    task automatic run_to_done(input int delay, input string tag);
        int n = 0;
        while (cpu_start !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (cpu_start !== 1'b0) begin
            errs++;
            $display("FAIL %s_release: cpu_start=%b required 0", tag, cpu_start);
        end
        vec++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL %s_busy_run: busy=%b required 1", tag, busy);
        end
        repeat (delay) @(negedge clk);
        vec++;
        if (load_done !== 1'b0) begin
            errs++;
            $display("FAIL %s_done_early: load_done=%b required 0", tag, load_done);
        end
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        vec++;
        if (load_done !== 1'b1 || cpu_start !== 1'b1) begin
            errs++;
            $display("FAIL %s_fin: load_done=%b cpu_start=%b required 1 1", tag, load_done,
                     cpu_start);
        end
        @(negedge clk);
        vec++;
        if (load_done !== 1'b0 || busy !== 1'b0 || cpu_start !== 1'b1) begin
            errs++;
            $display("FAIL %s_idle: load_done=%b busy=%b cpu_start=%b required 0 0 1", tag,
                     load_done, busy, cpu_start);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++;
        if (byte_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl: ready=%b we=%b busy=%b required 0 0 0", byte_ready,
                     mem_we, busy);
        end
        vec++;
        if (mem_addr !== 11'h000 || mem_data !== 9'h000) begin
            errs++;
            $display("FAIL reset_mem: addr=%h data=%h required 000 000", mem_addr, mem_data);
        end
        vec++;
        if (cpu_start !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_status: start=%b done=%b err=%b required 1 0 0", cpu_start,
                     load_done, load_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vec++;
        if (byte_ready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_ready: ready=%b busy=%b required 1 0", byte_ready, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_load();
        logic [10:0] exp_a[3];
        logic [8:0]  exp_d[3];
        logic [7:0]  bytes[8];
        int n = 0;
        exp_a = '{11'h000, 11'h001, 11'h002};
        exp_d = '{9'h1A5, 9'h042, 9'h0FF};
        bytes = '{8'h03, 8'h00, 8'hA5, 8'h01, 8'h42, 8'h00, 8'hFF, 8'h00};
        clear_log();
        for (int i = 0; i < 8; i++) send_byte(bytes[i], 1'b0);
        while (cpu_start !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (wa.size() != 3) begin
            errs++;
            $display("FAIL basic_count: writes=%0d required 3", wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vec++;
                if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i] || wr_rdy[i] !== 1'b0) begin
                    errs++;
                    $display("FAIL basic_write%0d: addr=%h data=%h ready=%b required %h %h 0",
                             i, wa[i], wd[i], wr_rdy[i], exp_a[i], exp_d[i]);
                end
            end
            vec++;
            if (wc[1] - wc[0] != 3 || wc[2] - wc[1] != 3) begin
                errs++;
                $display("FAIL basic_rate: spacing=%0d,%0d required 3,3", wc[1] - wc[0],
                         wc[2] - wc[1]);
            end
            vec++;
            if (cyc - wc[2] != 3) begin
                errs++;
                $display("FAIL basic_release: cycles_after_write=%0d required 3", cyc - wc[2]);
            end
        end
        vec++;
        if (mem_addr !== 11'h003) begin
            errs++;
            $display("FAIL basic_addr_after: addr=%h required 003", mem_addr);
        end
        run_to_done(1, "basic");
    endtask

    task automatic test_empty();
        clear_log();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        vec++;
        if (busy !== 1'b1 || cpu_start !== 1'b1) begin
            errs++;
            $display("FAIL empty_hold: busy=%b start=%b required 1 1", busy, cpu_start);
        end
        run_to_done(5, "empty");
        vec++;
        if (wa.size() != 0) begin
            errs++;
            $display("FAIL empty_writes: writes=%0d required 0", wa.size());
        end
    endtask

    task automatic test_hdr_err();
        clear_log();
        send_byte(8'h00, 1'b0);
        send_byte(8'h09, 1'b0);
        @(negedge clk);
        vec++;
        if (load_err !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b1) begin
            errs++;
            $display("FAIL err_set: err=%b busy=%b ready=%b required 1 0 1", load_err, busy,
                     byte_ready);
        end
        repeat (3) @(negedge clk);
        vec++;
        if (wa.size() != 0 || load_err !== 1'b1) begin
            errs++;
            $display("FAIL err_sticky: writes=%0d err=%b required 0 1", wa.size(), load_err);
        end
        @(posedge clk);
        #1;
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        vec++;
        if (load_err !== 1'b0) begin
            errs++;
            $display("FAIL err_clear: err=%b required 0", load_err);
        end
        @(posedge clk);
        #1;
        send_byte(8'h00, 1'b0);
        run_to_done(2, "err");
    endtask

    task automatic test_gaps();
        logic [8:0] exp_d[4];
        logic [7:0] bytes[10];
        exp_d = '{9'h123, 9'h0AB, 9'h1FE, 9'h001};
        // Last high byte 0xFE: bits 7:1 ignored, bit 0 = 0.
        bytes = '{8'h04, 8'h00, 8'h23, 8'h01, 8'hAB, 8'h00, 8'hFE, 8'h01, 8'h01, 8'hFE};
        clear_log();
        for (int i = 0; i < 10; i++) send_byte(bytes[i], 1'b1);
        run_to_done(0, "gaps");
        vec++;
        if (wa.size() != 4) begin
            errs++;
            $display("FAIL gaps_count: writes=%0d required 4", wa.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec++;
                if (wa[i] !== 11'(i) || wd[i] !== exp_d[i]) begin
                    errs++;
                    $display("FAIL gaps_write%0d: addr=%h data=%h required %h %h", i, wa[i],
                             wd[i], 11'(i), exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes[6];
        bytes = '{8'h03, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01};
        clear_log();
        for (int i = 0; i < 6; i++) send_byte(bytes[i], 1'b0);
        // Now in the 2nd WRITE cycle; step to the following cycle.
        @(posedge clk);
        #1;
        vec++;
        if (mem_addr !== 11'h002 || busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_pre: addr=%h busy=%b required 002 1", mem_addr, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        vec++;
        if (mem_addr !== 11'h000 || mem_data !== 9'h000 || mem_we !== 1'b0 || busy !== 1'b0 ||
            cpu_start !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0 ||
            load_err !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset: addr=%h data=%h we=%b busy=%b start=%b ready=%b required 000 000 0 0 1 0",
                     mem_addr, mem_data, mem_we, busy, cpu_start, byte_ready);
        end
        reset = 1'b0;
        clear_log();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h01, 1'b0);
        run_to_done(1, "mid");
        vec++;
        if (wa.size() != 1 || wa[0] !== 11'h000 || wd[0] !== 9'h15A) begin
            errs++;
            $display("FAIL mid_fresh: writes=%0d addr=%h data=%h required 1 000 15A", wa.size(),
                     wa.size() > 0 ? wa[0] : 11'h0, wd.size() > 0 ? wd[0] : 9'h0);
        end
    endtask

    task automatic test_full();
        int bad = 0;
        clear_log();
        send_byte(8'h00, 1'b0);
        send_byte(8'h08, 1'b0);
        for (int i = 0; i < 2048; i++) begin
            send_byte(8'(i), {7'b0, i[8]});
            send_byte({7'b0, i[8]}, 1'b0);
        end
        run_to_done(2, "full");
        vec++;
        if (wa.size() != 2048) begin
            errs++;
            $display("FAIL full_count: writes=%0d required 2048", wa.size());
        end else begin
            for (int i = 0; i < 2048; i++) begin
                if (wa[i] !== 11'(i) || wd[i] !== 9'(i)) bad++;
            end
            vec++;
            if (bad != 0) begin
                errs++;
                $display("FAIL full_seq: bad_writes=%0d required 0", bad);
            end
            vec++;
            if (wa[2047] !== 11'h7FF || wd[2047] !== 9'h1FF) begin
                errs++;
                $display("FAIL full_last: addr=%h data=%h required 7FF 1FF", wa[2047],
                         wd[2047]);
            end
        end
        vec++;
        if (mem_addr !== 11'h000) begin
            errs++;
            $display("FAIL full_wrap: addr=%h required 000", mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_empty();
        test_hdr_err();
        test_gaps();
        test_reset_mid();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
